bus_arbiter: RTL

Two-master round-robin arbiter for the shared serial system bus. Each master raises a request, and the arbiter grants exactly one master at a time. It drives the address/data mux select and holds the grant until the slave side signals transfer completion, the master withdraws its request, or a watchdog expires. It sits between the master-side ports and the slave-side in/out ports.

---
 rtl/bus_arbiter_if.sv | 19 +
 rtl/bus_arbiter.sv | 56 +++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant/mux-select bundle between the masters and the arbiter
interface bus_arbiter_if;
  logic m1_req;
  logic m2_req;
  logic bus_done;
  logic m1_grant;
  logic m2_grant;
  logic msel;
  logic bus_busy;
  logic timeout_err;
  modport master (
    output m1_req, m2_req, bus_done,
    input  m1_grant, m2_grant, msel, bus_busy, timeout_err
  );
  modport slave (
    input  m1_req, m2_req, bus_done,
    output m1_grant, m2_grant, msel, bus_busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with done/abort/watchdog release
module bus_arbiter #(
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  bus_arbiter_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, RELEASE} state_t;
  state_t state;
  logic last_owner;
  logic [WW-1:0] wd;
  logic pick2;
  logic cur_req;
  assign pick2 = bus.m2_req && (!bus.m1_req || !last_owner);
  assign cur_req = (state == GRANT1) ? bus.m1_req : bus.m2_req;
  // state machine with registered grant, select, busy and watchdog-error outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_owner      <= 1'b1;
      wd              <= '0;
      bus.m1_grant    <= 1'b0;
      bus.m2_grant    <= 1'b0;
      bus.msel        <= 1'b0;
      bus.bus_busy    <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: if (bus.m1_req || bus.m2_req) begin
          state        <= pick2 ? GRANT2 : GRANT1;
          bus.m1_grant <= !pick2;
          bus.m2_grant <= pick2;
          bus.msel     <= pick2;
          bus.bus_busy <= 1'b1;
          last_owner   <= pick2;
          wd           <= '0;
        end
        GRANT1, GRANT2: if (bus.bus_done || !cur_req || wd == WW'(TIMEOUT - 1)) begin
          state           <= RELEASE;
          bus.m1_grant    <= 1'b0;
          bus.m2_grant    <= 1'b0;
          bus.timeout_err <= !bus.bus_done && cur_req;
        end else begin
          wd <= wd + 1'b1;
        end
        default: begin
          state        <= IDLE;
          bus.bus_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
